// File: rtl/ports_input_filter_if.sv
// Pad/SFR bundle for the port input filter.
//   master : drives pad values and SFR controls, observes filtered values and flags
//   slave  : the filter itself
// Signals: y_pad (raw pads), pxen (1 = output pin), pxie (irq enable),
//          pxes (0 = rising, 1 = falling), pxdb (debounce threshold),
//          pxif_clr (write-1-to-clear pulses), y_port (filtered pins),
//          pxif (sticky flags), irq (combined request, combinational).
interface ports_input_filter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DBNC_W = 4
);
  logic [WIDTH-1:0]  y_pad;
  logic [WIDTH-1:0]  pxen;
  logic [WIDTH-1:0]  pxie;
  logic [WIDTH-1:0]  pxes;
  logic [DBNC_W-1:0] pxdb;
  logic [WIDTH-1:0]  pxif_clr;
  logic [WIDTH-1:0]  y_port;
  logic [WIDTH-1:0]  pxif;
  logic              irq;

  modport master (
    output y_pad, pxen, pxie, pxes, pxdb, pxif_clr,
    input  y_port, pxif, irq
  );

  modport slave (
    input  y_pad, pxen, pxie, pxes, pxdb, pxif_clr,
    output y_port, pxif, irq
  );
endinterface

// File: rtl/ports_input_filter.sv
// Per-pin input conditioning: synchronise pads, debounce with a shared
// programmable stable-time threshold, detect selected edges on input pins
// into sticky flags, and combine enabled flags into one interrupt request.
// Ports:
//   clk_i : core clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : ports_input_filter_if.slave (pads, SFR controls, filtered values, flags, irq)
// SYNC_STAGES must be at least 2.
module ports_input_filter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBNC_W      = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  ports_input_filter_if.slave bus
);

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [DBNC_W-1:0] cnt_q  [WIDTH];
  logic [DBNC_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0]  y_q;
  logic [WIDTH-1:0]  y_d;
  logic [WIDTH-1:0]  pxif_q;
  logic [WIDTH-1:0]  pxif_d;
  logic [WIDTH-1:0]  s;
  logic [WIDTH-1:0]  set;

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce and edge detection; counter is bounded by the threshold so it never wraps.
  always_comb begin
    y_d = y_q;
    set = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == y_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= bus.pxdb) begin
        y_d[i]   = s[i];
        cnt_d[i] = '0;
        // s differs from y here, so s = 1 means a rising update
        set[i]   = !bus.pxen[i] && (bus.pxes[i] ^ s[i]);
      end else begin
        cnt_d[i] = cnt_q[i] + DBNC_W'(1);
      end
    end
    // set has priority over a coincident clear
    pxif_d = (pxif_q & ~bus.pxif_clr) | set;
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      y_q    <= '0;
      pxif_q <= '0;
    end else begin
      sync_q[0] <= bus.y_pad;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      y_q    <= y_d;
      pxif_q <= pxif_d;
    end
  end

  assign bus.y_port = y_q;
  assign bus.pxif   = pxif_q;
  assign bus.irq    = |(pxif_q & bus.pxie);

endmodule

// File: tb/tb_ports_input_filter.sv
// Self-checking bench for ports_input_filter: a reset/latency vector table plus
// hand-written sequences for glitches, edge selection, clear/set races,
// output pins, threshold rewrite and mid-count reset.
module tb_ports_input_filter;
  localparam int unsigned WIDTH       = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DBNC_W      = 4;

  logic clk = 1'b0;
  logic rst;

  ports_input_filter_if #(.WIDTH(WIDTH), .DBNC_W(DBNC_W)) bus ();

  ports_input_filter #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DBNC_W(DBNC_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] pxif;
    logic       irq;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [7:0] pad;
    logic [7:0] ey;
    logic [7:0] ef;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [7:0] pxen, pxie, pxes;
  logic [3:0] pxdb;

  task automatic check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    tests++;
    if (bus.y_port !== e.y) begin
      fails++;
      $display("FAIL %s y_port: got %02h expected %02h", name, bus.y_port, e.y);
    end
    tests++;
    if (bus.pxif !== e.pxif) begin
      fails++;
      $display("FAIL %s pxif: got %02h expected %02h", name, bus.pxif, e.pxif);
    end
    tests++;
    if (bus.irq !== e.irq) begin
      fails++;
      $display("FAIL %s irq: got %0b expected %0b", name, bus.irq, e.irq);
    end
  endtask

  // Drive one cycle of stimulus, queue expectations, compare after the edge.
  task automatic step(input string name, input logic r, input logic [7:0] pad,
                      input logic [7:0] clr, input logic [7:0] ey, input logic [7:0] ef);
    exp_t e;
    rst          = r;
    bus.y_pad    = pad;
    bus.pxen     = pxen;
    bus.pxie     = pxie;
    bus.pxes     = pxes;
    bus.pxdb     = pxdb;
    bus.pxif_clr = clr;
    e.y    = ey;
    e.pxif = ef;
    e.irq  = |(ef & pxie);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{rst: 1'b1, pad: 8'h00, ey: 8'h00, ef: 8'h00};
    tbl[1] = '{rst: 1'b1, pad: 8'h00, ey: 8'h00, ef: 8'h00};
    for (int i = 2; i < 7; i++) tbl[i] = '{rst: 1'b0, pad: 8'h01, ey: 8'h00, ef: 8'h00};
    tbl[7] = '{rst: 1'b0, pad: 8'h01, ey: 8'h01, ef: 8'h01};

    // Reset and 2+3+1 latency with rising-edge flag
    pxen = 8'h00; pxie = 8'h01; pxes = 8'h00; pxdb = 4'd3;
    for (int i = 0; i < 8; i++) step("latency", tbl[i].rst, tbl[i].pad, 8'h00, tbl[i].ey, tbl[i].ef);

    // 3-cycle glitch on pin 1 is rejected
    for (int e = 1; e <= 10; e++)
      step("glitch3", 1'b0, (e <= 3) ? 8'h03 : 8'h01, 8'h00, 8'h01, 8'h01);

    // 4-cycle pulse passes and lasts 4 cycles
    for (int e = 1; e <= 12; e++)
      step("pulse4", 1'b0, (e <= 4) ? 8'h03 : 8'h01, 8'h00,
           (e >= 6 && e <= 9) ? 8'h03 : 8'h01, (e >= 6) ? 8'h03 : 8'h01);
    step("clr_all", 1'b0, 8'h01, 8'hFF, 8'h01, 8'h00);

    // No debounce, falling-edge select on pin 2
    pxdb = 4'd0; pxes = 8'h04;
    for (int e = 1; e <= 5; e++)
      step("rise_pxes1", 1'b0, 8'h05, 8'h00, (e >= 3) ? 8'h05 : 8'h01, 8'h00);
    for (int e = 1; e <= 5; e++)
      step("fall_pxes1", 1'b0, 8'h01, 8'h00, (e >= 3) ? 8'h01 : 8'h05, (e >= 3) ? 8'h04 : 8'h00);
    pxie = 8'h04;
    step("irq_pin2", 1'b0, 8'h01, 8'h00, 8'h01, 8'h04);
    step("clr_pin2", 1'b0, 8'h01, 8'h04, 8'h01, 8'h00);
    pxes = 8'h00;
    for (int e = 1; e <= 4; e++)
      step("rise_pxes0", 1'b0, 8'h05, 8'h00, (e >= 3) ? 8'h05 : 8'h01, (e >= 3) ? 8'h04 : 8'h00);
    step("clr_pin2b", 1'b0, 8'h05, 8'h04, 8'h05, 8'h00);
    for (int e = 1; e <= 4; e++)
      step("fall_pxes0", 1'b0, 8'h01, 8'h00, (e >= 3) ? 8'h01 : 8'h05, 8'h00);

    // Set and clear on the same edge: set wins; later clear drops irq
    pxie = 8'h01;
    for (int e = 1; e <= 4; e++)
      step("pin0_low", 1'b0, 8'h00, 8'h00, (e >= 3) ? 8'h00 : 8'h01, 8'h00);
    step("set_vs_clr", 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    step("set_vs_clr", 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    step("set_vs_clr", 1'b0, 8'h01, 8'h01, 8'h01, 8'h01);
    step("clr_only", 1'b0, 8'h01, 8'h01, 8'h01, 8'h00);

    // Output pins filter but never flag
    pxen = 8'hFF;
    for (int e = 1; e <= 4; e++)
      step("out_rise", 1'b0, 8'hFF, 8'h00, (e >= 3) ? 8'hFF : 8'h01, 8'h00);
    pxes = 8'hFF;
    for (int e = 1; e <= 4; e++)
      step("out_fall", 1'b0, 8'h00, 8'h00, (e >= 3) ? 8'h00 : 8'hFF, 8'h00);
    pxen = 8'h00; pxes = 8'h00;

    // Threshold lowered mid-count: update on the next edge
    pxdb = 4'hF;
    for (int e = 1; e <= 10; e++)
      step("count_to_8", 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);
    pxdb = 4'd2;
    step("pxdb_lower", 1'b0, 8'h01, 8'h00, 8'h01, 8'h01);

    // Reset mid-count clears everything; held pad rises after release
    pxdb = 4'hF;
    for (int e = 1; e <= 5; e++)
      step("pre_reset", 1'b0, 8'h03, 8'h00, 8'h01, 8'h01);
    step("mid_reset", 1'b1, 8'h03, 8'h00, 8'h00, 8'h00);
    pxdb = 4'd3;
    for (int e = 1; e <= 6; e++)
      step("post_reset", 1'b0, 8'h03, 8'h00, (e >= 6) ? 8'h03 : 8'h00, (e >= 6) ? 8'h03 : 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ports_input_filter.md
Name: ports_input_filter

Overview:
- Per-pin input conditioning stage between the raw pad inputs and the port SFR read path.
- Synchronises each asynchronous pad input to the core clock and debounces it with a programmable stable-time counter.
- Drives the filtered value to the port block's y_portX_i input.
- Detects selected edges on input-configured pins and raises sticky interrupt flags plus one combined interrupt request for the interrupt controller.

Parameters:
- WIDTH, 8, number of port pins handled.
- SYNC_STAGES, 2, synchroniser flip-flop depth per pin (minimum 2).
- DBNC_W, 4, width of the debounce threshold and of each per-pin counter.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- y_pad_i  input  WIDTH  raw asynchronous pad input values.
- ports_sfr_PXEN_i  input  WIDTH  pin direction from SFR; 1 = output pin, 0 = input pin.
- ports_sfr_PXIE_i  input  WIDTH  per-pin interrupt enable.
- ports_sfr_PXES_i  input  WIDTH  per-pin edge select; 0 = rising, 1 = falling.
- ports_sfr_PXDB_i  input  DBNC_W  debounce threshold, shared by all pins.
- ports_sfr_PXIF_clr_i  input  WIDTH  one-cycle write-1-to-clear pulses for the flags.
- y_portX_o  output  WIDTH  filtered pin values; feeds y_portX_i of the port block.
- ports_sfr_PXIF_o  output  WIDTH  sticky edge-detected interrupt flags.
- irq_portX_o  output  1  combined interrupt request.

Behaviour:
- One clock domain, clk_i. rst_i is synchronous and active-high.
- Reset values: all synchroniser registers 0; y_portX_o = 0; all counters 0; ports_sfr_PXIF_o = 0; irq_portX_o = 0.
- Synchroniser: per-pin chain of SYNC_STAGES flops. Let s[i] be the last stage output.
- Debounce, per pin, evaluated each edge in this priority order:
  - s[i] == y_portX_o[i]: cnt[i] <= 0.
  - else if cnt[i] >= ports_sfr_PXDB_i: y_portX_o[i] <= s[i] and cnt[i] <= 0. This is the "update" event.
  - else: cnt[i] <= cnt[i] + 1.
- The >= compare covers a threshold lowered mid-count: the update happens on the next edge.
- The counter never wraps, because cnt is bounded by the threshold.
- Latency: a pad change that stays stable appears on y_portX_o exactly SYNC_STAGES + PXDB + 1 rising edges after it is first sampled.
- Glitch rejection: any pulse shorter than PXDB + 1 cycles at s is rejected, since the counter restarts on a mismatch break.
- PXDB = 0 means no debounce; latency is SYNC_STAGES + 1.
- Filtering runs for every pin regardless of PXEN, so output pins read back the pad.
- Edge detection, per pin, fires only on an update event where ports_sfr_PXEN_i[i] = 0.
  - Rising event: PXES[i] = 0 and new value 1.
  - Falling event: PXES[i] = 1 and new value 0.
  - On an event, ports_sfr_PXIF_o[i] <= 1 on the same edge that updates y_portX_o[i].
- Flags are sticky. PXIF_clr_i[i] = 1 clears the flag on the next edge.
  - If set and clear coincide on the same edge, set wins and the flag stays 1.
- PXIE does not gate flag setting. It only gates the request: irq_portX_o = OR over i of (PXIF_o[i] AND PXIE_i[i]), combinational from registers and inputs.
- Direction change:
  - PXEN going 1 to 0 mid-debounce does not reset the counter.
  - An update occurring while PXEN[i] = 1 never sets a flag.
- Reset mid-operation clears everything on that edge. A pad held at 1 through reset then produces a rising update SYNC_STAGES + PXDB + 1 cycles after reset release, which sets the flag if the pin is an input with PXES = 0. Firmware enables interrupts only after clearing flags.

Test Plan:
- Reset, PXDB = 3: y_pad_i = 0x00 to 0x01 held -> y_portX_o[0] = 1 exactly 6 edges later (2+3+1); PXEN = 0 and PXES = 0 give PXIF_o = 0x01 on that same edge; PXIE = 0x01 gives irq_portX_o = 1.
- PXDB = 3: pad[1] glitch high for 3 cycles, then low -> y_portX_o[1] stays 0, PXIF_o[1] stays 0; a 4-cycle pulse -> y_portX_o[1] goes high for 4 cycles.
- PXDB = 0, PXES[2] = 1, pin 2 high and stable, then driven low -> y_portX_o[2] falls 3 edges later and PXIF_o[2] = 1; with PXES[2] = 0 instead, the falling edge leaves PXIF_o[2] = 0.
- PXIF_o[0] = 1 with PXIF_clr_i = 0x01 for one cycle -> flag cleared next edge and irq drops; repeat with clear on the same edge as a new event -> flag remains 1.
- PXEN = 0xFF, pad toggles 0x00 to 0xFF -> y_portX_o = 0xFF after latency, PXIF_o remains 0x00.
- PXDB = 0xF with cnt mid-count at 8, PXDB rewritten to 2 -> update on the next edge; rst_i asserted mid-count -> all outputs 0 on that edge.
